// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared constants for the multi-cycle MIPS main controller.
//   - state_t   : controller states (JR exists only when MC_JR_EN is defined)
//   - OP_* / FUNCT_JR : opcode and funct constants
//   - ALUOP_*, REGDST_*, MTR_*, SRCB_*, PCSRC_* : datapath select encodings
//   - ctrl_t    : packed control vector produced by mc_ctrl_outdec
//   - op_legal(): true for every opcode the core implements
// Optional feature macro: MC_JR_EN (adds the jr instruction).
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEM_ADDR,
    MEM_RD,
    MEM_WB,
    MEM_WR,
    R_EXEC,
    R_WB,
    I_EXEC,
    I_WB,
    BRANCH,
    JUMP,
`ifdef MC_JR_EN
    JAL,
    JR
`else
    JAL
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;
  localparam logic [1:0] ALUOP_SLT   = 2'd3;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [1:0] MTR_ALUOUT = 2'd0;
  localparam logic [1:0] MTR_MDR    = 2'd1;
  localparam logic [1:0] MTR_PC     = 2'd2;

  localparam logic [1:0] SRCB_BREG    = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_JUMP   = 2'd1;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd2;
  localparam logic [1:0] PCSRC_AREG   = 2'd3;

  typedef struct packed {
    logic       pc_write;
    logic       pc_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
      OP_ADDI, OP_SLTI, OP_J, OP_JAL: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// mc_ctrl_outdec: combinational state -> control vector decoder (Moore outputs).
//   state   in  current controller state
//   is_slti in  I-type flag latched in DECODE (1 = slti, 0 = addi)
//   op_bad  in  current opcode is unsupported; only consulted in DECODE
//   ctrl    out full datapath control vector
// Optional feature macro: MC_JR_EN (JR state decode).
import mc_ctrl_pkg::*;

module mc_ctrl_outdec (
  input  state_t state,
  input  logic   is_slti,
  input  logic   op_bad,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        ctrl.pc_write  = 1'b1;
      end
      DECODE: begin
        // Branch target precomputed into ALUout; illegal opcodes retire here.
        ctrl.alu_src_b  = SRCB_IMM_SH2;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.illegal_op = op_bad;
        ctrl.instr_done = op_bad;
      end
      MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REGDST_RT;
        ctrl.mem_to_reg = MTR_MDR;
        ctrl.instr_done = 1'b1;
      end
      MEM_WR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_BREG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REGDST_RD;
        ctrl.mem_to_reg = MTR_ALUOUT;
        ctrl.instr_done = 1'b1;
      end
      I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = is_slti ? ALUOP_SLT : ALUOP_ADD;
      end
      I_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REGDST_RT;
        ctrl.mem_to_reg = MTR_ALUOUT;
        ctrl.instr_done = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_BREG;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.pc_cond    = 1'b1;
        ctrl.pc_src     = PCSRC_ALUOUT;
        ctrl.instr_done = 1'b1;
      end
      JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_src     = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      JAL: begin
        // PC already holds PC+4 from FETCH: that is the return address.
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REGDST_RA;
        ctrl.mem_to_reg = MTR_PC;
        ctrl.pc_write   = 1'b1;
        ctrl.pc_src     = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
`ifdef MC_JR_EN
      JR: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_src     = PCSRC_AREG;
        ctrl.instr_done = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore main control FSM for the multi-cycle MIPS core.
//   clk, rst      : clock, synchronous active-high reset
//   opCode        : IR[31:26]; only consulted in DECODE
//   funct         : IR[5:0]; present only with MC_JR_EN
//   pcWrite .. PCSrc : datapath enables / selects
//   instrDone     : pulse in the last state of each instruction
//   illegalOp     : pulse in DECODE for an unsupported opcode
// Optional feature macro: MC_JR_EN (jr support, adds funct port and JR state).
import mc_ctrl_pkg::*;

module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opCode,
`ifdef MC_JR_EN
  input  logic [5:0] funct,
`endif
  output logic       pcWrite,
  output logic       pcConditional,
  output logic       IorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       IRWrite,
  output logic       regWrite,
  output logic       ALUSrcA,
  output logic [1:0] regDst,
  output logic [1:0] memtoreg,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       instrDone,
  output logic       illegalOp
);

  state_t state, state_next;
  logic   is_slti;   // I-type flavour, captured in DECODE
  logic   is_load;   // lw vs sw, captured in DECODE so MEM_ADDR never reads opCode
  logic   op_bad;
  ctrl_t  ctrl, ctrl_out;

  assign op_bad = !op_legal(opCode);

  // State register and DECODE-time flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      is_slti <= 1'b0;
      is_load <= 1'b0;
    end else begin
      state <= state_next;
      if (state == DECODE) begin
        is_slti <= (opCode == OP_SLTI);
        is_load <= (opCode == OP_LW);
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH:  state_next = DECODE;
      DECODE: begin
        case (opCode)
          OP_LW, OP_SW:     state_next = MEM_ADDR;
`ifdef MC_JR_EN
          OP_RTYPE:         state_next = (funct == FUNCT_JR) ? JR : R_EXEC;
`else
          OP_RTYPE:         state_next = R_EXEC;
`endif
          OP_BEQ:           state_next = BRANCH;
          OP_ADDI, OP_SLTI: state_next = I_EXEC;
          OP_J:             state_next = JUMP;
          OP_JAL:           state_next = JAL;
          default:          state_next = FETCH;
        endcase
      end
      MEM_ADDR: state_next = is_load ? MEM_RD : MEM_WR;
      MEM_RD:   state_next = MEM_WB;
      R_EXEC:   state_next = R_WB;
      I_EXEC:   state_next = I_WB;
      default:  state_next = FETCH;  // every terminal state returns to FETCH
    endcase
  end

  // Output decode
  mc_ctrl_outdec u_outdec (
    .state   (state),
    .is_slti (is_slti),
    .op_bad  (op_bad),
    .ctrl    (ctrl)
  );

  // Nothing reaches the datapath while reset is held, even mid-instruction.
  assign ctrl_out = rst ? '0 : ctrl;

  assign pcWrite       = ctrl_out.pc_write;
  assign pcConditional = ctrl_out.pc_cond;
  assign IorD          = ctrl_out.i_or_d;
  assign memRead       = ctrl_out.mem_read;
  assign memWrite      = ctrl_out.mem_write;
  assign IRWrite       = ctrl_out.ir_write;
  assign regWrite      = ctrl_out.reg_write;
  assign ALUSrcA       = ctrl_out.alu_src_a;
  assign regDst        = ctrl_out.reg_dst;
  assign memtoreg      = ctrl_out.mem_to_reg;
  assign ALUSrcB       = ctrl_out.alu_src_b;
  assign ALUOp         = ctrl_out.alu_op;
  assign PCSrc         = ctrl_out.pc_src;
  assign instrDone     = ctrl_out.instr_done;
  assign illegalOp     = ctrl_out.illegal_op;

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control unit for the multi-cycle MIPS core. A Moore state machine that sequences each instruction through fetch, decode, execute, memory and write-back. It consumes the 6-bit opcode from the datapath's instruction register and drives every datapath control select and enable. It also emits per-instruction status pulses for the bench.

## Interface
- No parameters; all encodings are fixed constants in the shared package.
- clk  in  1  rising-edge clock; one clock for the whole block
- rst  in  1  reset, synchronous and active-high
- opCode  in  6  instruction[31:26] from the datapath IR
- funct  in  6  instruction[5:0]; present only with MC_JR_EN
- pcWrite, pcConditional, IorD, memRead, memWrite, IRWrite, regWrite, ALUSrcA  out  1 each  datapath enables/selects
- regDst  out  2  write register: 0 rt, 1 rd, 2 $31
- memtoreg  out  2  write data: 0 ALUout, 1 MDR, 2 PC
- ALUSrcB  out  2  ALU B operand: 0 B reg, 1 const 4, 2 sign-extended imm, 3 sign-extended imm<<2
- ALUOp  out  2  0 add, 1 sub, 2 use funct, 3 set-less-than
- PCSrc  out  2  next PC: 0 ALU out, 1 jump target, 2 ALUout reg, 3 A reg
- instrDone  out  1  one-cycle pulse in the last state of every instruction
- illegalOp  out  1  one-cycle pulse in DECODE when the opcode is unsupported

## Operation
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, slti 001010, j 000010, jal 000011. Any other opcode is illegal.
- Control outputs not listed for a state are 0.
- FETCH: memRead=1, IRWrite=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSrc=0, pcWrite=1. Next state: DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=0 (branch target goes into the ALUout reg). Next state by opCode:
  - lw/sw -> MEM_ADDR
  - R-type -> R_EXEC (or JR, see Configuration)
  - beq -> BRANCH
  - addi/slti -> I_EXEC
  - j -> JUMP
  - jal -> JAL
  - illegal -> FETCH
- MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ALUOp=0. Next: MEM_RD for lw, MEM_WR for sw.
- MEM_RD: memRead=1, IorD=1. Next: MEM_WB.
- MEM_WB: regWrite=1, regDst=0, memtoreg=1. Then FETCH.
- MEM_WR: memWrite=1, IorD=1. Then FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=0, ALUOp=2. Next: R_WB.
- R_WB: regWrite=1, regDst=1, memtoreg=0. Then FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=2, ALUOp=0 for addi, 3 for slti. The addi/slti choice is latched in DECODE into an internal flag. Next: I_WB.
- I_WB: regWrite=1, regDst=0, memtoreg=0. Then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=1, pcConditional=1, PCSrc=2. Then FETCH.
- JUMP: pcWrite=1, PCSrc=1. Then FETCH.
- JAL: regWrite=1, regDst=2, memtoreg=2, pcWrite=1, PCSrc=1. The PC already holds PC+4 from FETCH, so $31 receives the return address. Then FETCH.
- instrDone=1 in: MEM_WB, MEM_WR, R_WB, I_WB, BRANCH, JUMP, JAL, JR, and DECODE on an illegal opcode.

## Timing
- State register updates on the rising edge of clk. Outputs decode only from the current state and the latched I-type flag. illegalOp and the DECODE-state instrDone also use opCode. No opCode-to-enable combinational path exists outside DECODE.
- opCode is sampled only in DECODE. IR changes only in FETCH, so the sample is stable.
- Reset: while rst=1, every output is forced to 0. On the edge where rst=1, state is set to FETCH and the I-type flag is cleared. The first cycle after rst falls is FETCH.
- Reset asserted mid-instruction aborts it at the next edge. No partial write enable is asserted while rst=1.
- Cycles per instruction, FETCH included:
  - lw 5
  - sw, R-type, addi, slti 4
  - beq, j, jal, jr 3
  - illegal 2
- Back-to-back instructions have no idle cycle: the final state always transitions to FETCH.

## Configuration
- MC_JR_EN defined:
  - funct port exists.
  - In DECODE, R-type with funct=001000 goes to JR instead of R_EXEC.
  - JR: pcWrite=1, PCSrc=3. Then FETCH.
- MC_JR_EN undefined:
  - No funct port and no JR state.
  - funct 001000 executes as an ordinary R-type (R_EXEC, R_WB). PCSrc=3 is never driven.

## Structure
- Package mc_ctrl_pkg holds:
  - the state enum (FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, JAL, JR)
  - the opcode and funct constants
  - the ALUOp, regDst, memtoreg, ALUSrcB and PCSrc encodings
- One sub-module, mc_ctrl_outdec: a purely combinational state-to-control-vector decoder. The top level holds the state register, next-state logic, I-type flag and reset gating.

## Test plan
- Reset: rst=1 for 3 cycles mid-MEM_RD -> all outputs 0 during rst; first cycle after release shows memRead=1, IRWrite=1, pcWrite=1.
- lw (opCode 100011) -> states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB over 5 cycles; MEM_WB has regWrite=1, memtoreg=1, regDst=0; instrDone pulses once in cycle 5.
- beq then j (000100, 000010) -> 3 cycles each; BRANCH has pcConditional=1, PCSrc=2, ALUOp=1; JUMP has pcWrite=1, PCSrc=1; never regWrite.
- jal (000011) -> JAL has regDst=2, memtoreg=2, regWrite=1, pcWrite=1, PCSrc=1; next cycle is FETCH.
- slti then addi (001010, 001000) -> I_EXEC ALUOp=3 then 0; I_WB regDst=0.
- Opcode 111111 -> illegalOp and instrDone pulse in DECODE, return to FETCH, no write enable asserted.
- With MC_JR_EN: opCode 0, funct 001000 -> JR with PCSrc=3, pcWrite=1.
